// File: rtl/mc_array_seq.sv
// mc_array_seq -- clocked behavioural model and controller for a ROWS x COLS
// complementary-memristor compute array. Each cell holds two memristor states
// (m0, m1). PROGRAM writes m0=wdata then m1=~wdata in two pulse phases, CLEAR
// sets m0=m1=0, READ precharges then evaluates the per-column likelihood term
// ~((m0 & din) | (m1 & dinb)). Cells with m0==m1 are flagged in rerr_o.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   req_i, op_i, row_i    command request / opcode (00 RD, 01 PROG, 10 CLR, 11 illegal) / row
//   wdata_i, wmask_i      PROGRAM data, PROGRAM/CLEAR column mask
//   din_i, dinb_i         READ true / complement selects
//   ready_o               high only in IDLE; command accepted on req_i & ready_o
//   done_o, cmd_err_o     completion pulse, qualified by rejection flag
//   rvalid_o              read result pulse; rdata_o/rerr_o held until next read
//
// Build option: define MC_ENDURANCE_EN to add per-row saturating wear counters
// (ENDUR_W bits) that reject PROGRAM/CLEAR once a row's counter is all-ones.

module mc_array_seq #(
  parameter int unsigned ROWS     = 64,
  parameter int unsigned COLS     = 64,
  parameter int unsigned PROG_CYC = 2,
  parameter int unsigned PRE_CYC  = 1,
  parameter int unsigned ENDUR_W  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  input  logic [1:0]              op_i,
  input  logic [$clog2(ROWS)-1:0] row_i,
  input  logic [COLS-1:0]         wdata_i,
  input  logic [COLS-1:0]         wmask_i,
  input  logic [COLS-1:0]         din_i,
  input  logic [COLS-1:0]         dinb_i,
  output logic                    ready_o,
  output logic                    done_o,
  output logic                    rvalid_o,
  output logic [COLS-1:0]         rdata_o,
  output logic [COLS-1:0]         rerr_o,
  output logic                    cmd_err_o
);

  localparam int unsigned RW   = $clog2(ROWS);
  localparam int unsigned MAXC = (PROG_CYC > PRE_CYC) ? PROG_CYC : PRE_CYC;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] PROG_LAST = CW'(PROG_CYC - 1);
  localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_CYC - 1);

  typedef enum logic [2:0] {IDLE, PROG_M0, PROG_M1, CLR, PRECH, EVAL} state_t;
  typedef enum logic [1:0] {OP_READ = 2'b00, OP_PROG = 2'b01, OP_CLEAR = 2'b10,
                            OP_ILL = 2'b11} op_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   row_q;
  logic [COLS-1:0] wdata_q, wmask_q, din_q, dinb_q;

  logic [COLS-1:0] m0 [ROWS];
  logic [COLS-1:0] m1 [ROWS];

  logic ld_cmd, wr_m0, wr_m1, wr_clr, rd_cap, done_d, err_d;
  logic row_ok, wear_full, bad_cmd;
  op_t  op_in;

  assign op_in   = op_t'(op_i);
  assign row_ok  = 32'(row_i) < ROWS;
  assign ready_o = (state_q == IDLE);

`ifdef MC_ENDURANCE_EN
  logic [ENDUR_W-1:0] wear [ROWS];

  assign wear_full = ((op_in == OP_PROG) || (op_in == OP_CLEAR)) && row_ok &&
                     (&wear[row_i]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned r = 0; r < ROWS; r++) wear[r] <= '0;
    end else if ((wr_m1 || wr_clr) && !(&wear[row_q])) begin
      wear[row_q] <= wear[row_q] + ENDUR_W'(1);
    end
  end
`else
  assign wear_full = 1'b0;
  // ENDUR_W only sizes the wear counters; nothing is built from it here.
  if (ENDUR_W == 0) begin : g_no_wear
  end
`endif

  // Illegal opcode, out-of-range row and worn-out row all share one response.
  assign bad_cmd = (op_in == OP_ILL) || !row_ok || wear_full;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ld_cmd  = 1'b0;
    wr_m0   = 1'b0;
    wr_m1   = 1'b0;
    wr_clr  = 1'b0;
    rd_cap  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          ld_cmd = 1'b1;
          cnt_d  = '0;
          if (bad_cmd) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            case (op_in)
              OP_READ: state_d = PRECH;
              OP_PROG: state_d = PROG_M0;
              default: state_d = CLR;
            endcase
          end
        end
      end
      PROG_M0: begin
        if (cnt_q == PROG_LAST) begin
          cnt_d   = '0;
          wr_m0   = 1'b1;
          state_d = PROG_M1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PROG_M1: begin
        if (cnt_q == PROG_LAST) begin
          cnt_d   = '0;
          wr_m1   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CLR: begin
        if (cnt_q == PROG_LAST) begin
          cnt_d   = '0;
          wr_clr  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRECH: begin
        if (cnt_q == PRE_LAST) begin
          cnt_d   = '0;
          state_d = EVAL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      EVAL: begin
        rd_cap  = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q   <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      din_q   <= '0;
      dinb_q  <= '0;
    end else if (ld_cmd) begin
      row_q   <= row_i;
      wdata_q <= wdata_i;
      wmask_q <= wmask_i;
      din_q   <= din_i;
      dinb_q  <= dinb_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        m0[r] <= '0;
        m1[r] <= '0;
      end
    end else begin
      if (wr_m0) m0[row_q] <= (m0[row_q] & ~wmask_q) | (wdata_q & wmask_q);
      if (wr_m1) m1[row_q] <= (m1[row_q] & ~wmask_q) | (~wdata_q & wmask_q);
      if (wr_clr) begin
        m0[row_q] <= m0[row_q] & ~wmask_q;
        m1[row_q] <= m1[row_q] & ~wmask_q;
      end
    end
  end

  logic [COLS-1:0] m0_r, m1_r, rerr_n, rdata_n;

  always_comb begin
    m0_r    = m0[row_q];
    m1_r    = m1[row_q];
    rerr_n  = ~(m0_r ^ m1_r);
    rdata_n = ~rerr_n & ~((m0_r & din_q) | (m1_r & dinb_q));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_o    <= 1'b0;
      cmd_err_o <= 1'b0;
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
      rerr_o    <= '0;
    end else begin
      done_o    <= done_d;
      cmd_err_o <= err_d;
      rvalid_o  <= rd_cap;
      if (rd_cap) begin
        rdata_o <= rdata_n;
        rerr_o  <= rerr_n;
      end
    end
  end

endmodule

// File: tb/tb_mc_array_seq.sv
module tb_mc_array_seq;

  logic       clk, rst_n, req;
  logic [1:0] op;
  logic [2:0] row;
  logic [7:0] wdata, wmask, din, dinb;
  logic       ready, done, rvalid, cmd_err;
  logic [7:0] rdata, rerr;

  int checks = 0;
  int errors = 0;

  mc_array_seq #(
    .ROWS(6), .COLS(8), .PROG_CYC(2), .PRE_CYC(1), .ENDUR_W(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .op_i(op), .row_i(row),
    .wdata_i(wdata), .wmask_i(wmask), .din_i(din), .dinb_i(dinb),
    .ready_o(ready), .done_o(done), .rvalid_o(rvalid), .rdata_o(rdata),
    .rerr_o(rerr), .cmd_err_o(cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Issues one command from an IDLE-ready point (#1 after a rising edge) and
  // returns the number of rising edges after the accept edge until done is seen.
  task automatic run_cmd(input logic [1:0] o, input logic [2:0] r,
                         input logic [7:0] wd, input logic [7:0] wm,
                         input logic [7:0] di, input logic [7:0] dib,
                         output int lat, output logic err, output logic rv);
    int n = 0;
    while (!ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    req = 1'b1; op = o; row = r; wdata = wd; wmask = wm; din = di; dinb = dib;
    @(posedge clk); #1;
    req = 1'b0; op = 2'b00; row = 3'd0; wdata = 8'h00; wmask = 8'h00; din = 8'h00; dinb = 8'h00;
    lat = -1; err = 1'b0; rv = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (done) begin
        lat = k; err = cmd_err; rv = rvalid;
        break;
      end
      if (cmd_err || rvalid) begin
        checks++; errors++;
        $display("FAIL pulse_without_done cmd_err=%0b rvalid=%0b required=0", cmd_err, rvalid);
      end
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [2:0] row;
    logic [7:0] wd, wm, di, dib;
    int         lat;
    logic       err, rv;
    logic [7:0] rd, re;
  } vec_t;

  vec_t vecs [14];

  int   lat;
  logic err, rv;

  initial begin
    vecs[0]  = '{2'b01, 3'd3, 8'hA5, 8'hFF, 8'h00, 8'h00, 4, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[1]  = '{2'b00, 3'd3, 8'h00, 8'h00, 8'hFF, 8'h00, 2, 1'b0, 1'b1, 8'h5A, 8'h00};
    vecs[2]  = '{2'b00, 3'd3, 8'h00, 8'h00, 8'h00, 8'hFF, 2, 1'b0, 1'b1, 8'hA5, 8'h00};
    vecs[3]  = '{2'b00, 3'd5, 8'h00, 8'h00, 8'hFF, 8'h00, 2, 1'b0, 1'b1, 8'h00, 8'hFF};
    vecs[4]  = '{2'b01, 3'd3, 8'hFF, 8'h0F, 8'h00, 8'h00, 4, 1'b0, 1'b0, 8'h00, 8'hFF};
    vecs[5]  = '{2'b00, 3'd3, 8'h00, 8'h00, 8'h00, 8'hFF, 2, 1'b0, 1'b1, 8'hAF, 8'h00};
    vecs[6]  = '{2'b10, 3'd3, 8'h00, 8'hF0, 8'h00, 8'h00, 2, 1'b0, 1'b0, 8'hAF, 8'h00};
    vecs[7]  = '{2'b00, 3'd3, 8'h00, 8'h00, 8'h00, 8'hFF, 2, 1'b0, 1'b1, 8'h0F, 8'hF0};
    vecs[8]  = '{2'b11, 3'd3, 8'hFF, 8'hFF, 8'h00, 8'h00, 0, 1'b1, 1'b0, 8'h0F, 8'hF0};
    vecs[9]  = '{2'b00, 3'd3, 8'h00, 8'h00, 8'h00, 8'hFF, 2, 1'b0, 1'b1, 8'h0F, 8'hF0};
    vecs[10] = '{2'b00, 3'd3, 8'h00, 8'h00, 8'hFF, 8'h00, 2, 1'b0, 1'b1, 8'h00, 8'hF0};
    vecs[11] = '{2'b01, 3'd6, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 1'b1, 1'b0, 8'h00, 8'hF0};
    vecs[12] = '{2'b00, 3'd7, 8'h00, 8'h00, 8'hFF, 8'h00, 0, 1'b1, 1'b0, 8'h00, 8'hF0};
    vecs[13] = '{2'b00, 3'd3, 8'h00, 8'h00, 8'h00, 8'hFF, 2, 1'b0, 1'b1, 8'h0F, 8'hF0};

    rst_n = 1'b0; req = 1'b0; op = 2'b00; row = 3'd0;
    wdata = 8'h00; wmask = 8'h00; din = 8'h00; dinb = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_cmd_err", cmd_err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rerr", rerr, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Every command is issued in the done cycle of the previous one.
    for (int i = 0; i < 14; i++) begin
      run_cmd(vecs[i].op, vecs[i].row, vecs[i].wd, vecs[i].wm, vecs[i].di, vecs[i].dib,
              lat, err, rv);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_cmd_err", i), err, vecs[i].err);
      chk($sformatf("v%0d_rvalid", i), rv, vecs[i].rv);
      chk($sformatf("v%0d_rdata", i), rdata, vecs[i].rd);
      chk($sformatf("v%0d_rerr", i), rerr, vecs[i].re);
      chk($sformatf("v%0d_ready_in_done", i), ready, 1);
    end

    // Reset during PROG_M1: immediate abort, array cleared, no completion.
    req = 1'b1; op = 2'b01; row = 3'd3; wdata = 8'h3C; wmask = 8'hFF;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("prem1_ready_low", ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_cmd_err", cmd_err, 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_rerr", rerr, 0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("mid_rst_no_done", done, 0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_no_done", done, 0);
    run_cmd(2'b00, 3'd3, 8'h00, 8'h00, 8'hFF, 8'h00, lat, err, rv);
    chk("post_rst_rd_lat", lat, 2);
    chk("post_rst_rd_rvalid", rv, 1);
    chk("post_rst_rd_rdata", rdata, 8'h00);
    chk("post_rst_rd_rerr", rerr, 8'hFF);

`ifdef MC_ENDURANCE_EN
    run_cmd(2'b01, 3'd1, 8'h11, 8'hFF, 8'h00, 8'h00, lat, err, rv);
    chk("end_p1_lat", lat, 4); chk("end_p1_err", err, 0);
    run_cmd(2'b01, 3'd1, 8'h22, 8'hFF, 8'h00, 8'h00, lat, err, rv);
    chk("end_p2_lat", lat, 4); chk("end_p2_err", err, 0);
    run_cmd(2'b01, 3'd1, 8'h33, 8'hFF, 8'h00, 8'h00, lat, err, rv);
    chk("end_p3_lat", lat, 4); chk("end_p3_err", err, 0);
    run_cmd(2'b01, 3'd1, 8'h44, 8'hFF, 8'h00, 8'h00, lat, err, rv);
    chk("end_p4_lat", lat, 0); chk("end_p4_err", err, 1);
    run_cmd(2'b00, 3'd1, 8'h00, 8'h00, 8'hFF, 8'h00, lat, err, rv);
    chk("end_rd_err", err, 0);
    chk("end_rd_rdata", rdata, 8'hCC);
    chk("end_rd_rerr", rerr, 8'h00);
    run_cmd(2'b01, 3'd2, 8'h55, 8'hFF, 8'h00, 8'h00, lat, err, rv);
    chk("end_r2_lat", lat, 4); chk("end_r2_err", err, 0);
`else
    for (int k = 0; k < 4; k++) begin
      run_cmd(2'b01, 3'd1, 8'h11 * (k + 1), 8'hFF, 8'h00, 8'h00, lat, err, rv);
      chk($sformatf("noend_p%0d_lat", k), lat, 4);
      chk($sformatf("noend_p%0d_err", k), err, 0);
    end
    run_cmd(2'b00, 3'd1, 8'h00, 8'h00, 8'hFF, 8'h00, lat, err, rv);
    chk("noend_rd_rdata", rdata, 8'hBB);
    chk("noend_rd_rerr", rerr, 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_array_seq.md
Name: mc_array_seq

Overview:
Parametrised, clocked behavioural model and controller for a complementary-memristor compute array of ROWS x COLS cells. Each cell holds two memristor states (m0, m1). Programming sequences the two memristor pulses. Reads run a precharge/evaluate sequence and return the per-column likelihood term ~((m0 & din) | (m1 & dinb)). It replaces the unclocked fixed 64x64 array in the Bayesian tile with a request/response interface that the tile sequencer can drive.

Parameters:
ROWS, 64, number of word lines (>=2)
COLS, 64, number of bit/source-line columns
PROG_CYC, 2, cycles per memristor program pulse phase (>=1)
PRE_CYC, 1, precharge cycles before evaluate (>=1)
ENDUR_W, 8, width of per-row program counter (used only with MC_ENDURANCE_EN)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  1  command request
op_i  in  2  00 READ, 01 PROGRAM, 10 CLEAR, 11 illegal
row_i  in  $clog2(ROWS)  target row
wdata_i  in  COLS  logical bit per column for PROGRAM
wmask_i  in  COLS  1 = column affected by PROGRAM/CLEAR
din_i  in  COLS  read select (true branch)
dinb_i  in  COLS  read select (complement branch)
ready_o  out  1  command accepted when req_i & ready_o
done_o  out  1  one-cycle pulse at command completion
rvalid_o  out  1  one-cycle pulse, rdata_o/rerr_o updated
rdata_o  out  COLS  read result, held until next read
rerr_o  out  COLS  1 = cell has m0==m1 (unprogrammed or cleared)
cmd_err_o  out  1  qualifies done_o: command rejected

Behaviour:
- Clock clk_i; reset rst_ni is asynchronous and active-low.
- Reset: FSM to IDLE. ready_o=1. done_o, rvalid_o and cmd_err_o = 0. rdata_o and rerr_o = 0. All cells m0=m1=0. Wear counters = 0.
- Reset asserted mid-command aborts the command with no completion pulse. The array is cleared regardless of phase.
- States: IDLE, PROG_M0, PROG_M1, CLR, PRECH, EVAL.
- ready_o=1 only in IDLE. The handshake fires on the edge where req_i & ready_o (edge E0). That edge registers op, row, wdata, wmask, din and dinb. Inputs are ignored at all other times.
- Back-to-back: a new command can be accepted in the same cycle that done_o is high.
- PROGRAM: IDLE -> PROG_M0 for PROG_CYC cycles. The exit edge writes m0=wdata on masked columns. PROG_M0 -> PROG_M1 for PROG_CYC cycles. The exit edge writes m1=~wdata on masked columns, then IDLE. done_o is high in the cycle after edge E0+2*PROG_CYC. Unmasked columns are unchanged.
- CLEAR: IDLE -> CLR for PROG_CYC cycles. The exit edge sets m0=m1=0 on masked columns, then IDLE. done_o follows.
- READ: IDLE -> PRECH for PRE_CYC cycles -> EVAL for 1 cycle -> IDLE.
- The edge leaving EVAL (E0+PRE_CYC+1) registers rdata_o and rerr_o. rvalid_o and done_o pulse together.
- Per column c: rerr_o[c] = (m0==m1). rdata_o[c] = rerr_o[c] ? 0 : ~((m0 & din[c]) | (m1 & dinb[c])).
- Illegal op 11: accepted; done_o=1 and cmd_err_o=1 in the next cycle; no array change; state stays IDLE.
- cmd_err_o is 0 whenever done_o is 0.
- row_i >= ROWS (non-power-of-2 ROWS): treated as illegal, same response as op 11.

Optional Feature:
MC_ENDURANCE_EN:
- Defined: each row has an ENDUR_W-bit saturating counter, incremented on PROGRAM or CLEAR completion.
- A PROGRAM/CLEAR that targets a row whose counter is all-ones is rejected: done_o=1 and cmd_err_o=1 one cycle after E0, no array write, no counter change.
- READ is never rejected.
- Undefined: no counters; PROGRAM/CLEAR are never rejected; ENDUR_W is ignored.

Test Plan:
- Bench config COLS=8, PROG_CYC=2, PRE_CYC=1. PROGRAM row 3, wdata=0xA5, wmask=0xFF -> done_o 4 cycles after accept. READ row 3 with din=0xFF, dinb=0x00 -> rvalid_o 2 cycles after accept, rdata_o=0x5A, rerr_o=0x00.
- READ row 3 with din=0x00, dinb=0xFF -> rdata_o=0xA5. READ unprogrammed row 5 -> rerr_o=0xFF, rdata_o=0x00.
- PROGRAM row 3, wdata=0xFF, wmask=0x0F (over 0xA5); READ with din=0x00, dinb=0xFF -> rdata_o=0xAF. CLEAR row 3, wmask=0xF0; READ -> rerr_o=0xF0, rdata_o=0x0F.
- op=11 -> done_o=1 and cmd_err_o=1 one cycle after accept; subsequent READ of row 3 is unchanged. Back-to-back READ issued in the done_o cycle is accepted.
- Assert rst_ni during PROG_M1 -> outputs 0 immediately, ready_o=1, no done_o; READ row 3 -> rerr_o=0xFF.
- MC_ENDURANCE_EN, ENDUR_W=2: three PROGRAMs to row 1 succeed; fourth -> cmd_err_o=1, row contents unchanged; PROGRAM to row 2 still succeeds.
